// File: rtl/audio_sample_fifo_pkg.sv
// Shared audio types: default sample width and the stereo sample pair.
package audio_sample_fifo_pkg;

  localparam int AUDIO_WIDTH = 24;

  typedef struct packed {
    logic signed [AUDIO_WIDTH-1:0] left;
    logic signed [AUDIO_WIDTH-1:0] right;
  } stereo_t;

endpackage

// File: rtl/audio_sample_fifo_ram.sv
// Simple dual-port sample RAM: synchronous write, asynchronous read, no reset.
// Latency: write visible on the read port after the write edge; no backpressure.
module audio_fifo_ram #(
  parameter int DEPTH = 16,
  parameter int DW    = 48
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DW-1:0]            wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DW-1:0]            rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/audio_sample_fifo.sv
// Stereo sample FIFO feeding an I2S serializer through a registered output stage.
// Latency: two edges from write into an empty FIFO to l_data/r_data. Backpressure: in_ready=0 when memory is full.
// Optional underrun_cnt output is built when AUDIO_FIFO_UNDERRUN_CNT_EN is defined.
module audio_sample_fifo
  import audio_sample_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = AUDIO_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [WIDTH-1:0]    in_l,
  input  logic signed [WIDTH-1:0]    in_r,
  input  logic                       load,
  output logic signed [WIDTH-1:0]    l_data,
  output logic signed [WIDTH-1:0]    r_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       underrun,
  input  logic                       clr_underrun
`ifdef AUDIO_FIFO_UNDERRUN_CNT_EN
  ,
  output logic [15:0]                underrun_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic signed [WIDTH-1:0] left;
    logic signed [WIDTH-1:0] right;
  } sample_t;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          stage_full;
  logic          wr_en;
  logic          mem_empty;
  logic          refill;
  logic          drain;
  logic          underrun_set;
  sample_t       wr_word;
  sample_t       head;

  assign in_ready     = (level < (AW+1)'(DEPTH));
  assign wr_en        = in_valid & in_ready;
  assign mem_empty    = (level == '0);
  // Refill only from memory: a sample written this edge reaches the stage next edge.
  assign refill       = ~mem_empty & (~stage_full | load);
  assign drain        = load & stage_full & mem_empty;
  assign underrun_set = load & ~stage_full;

  assign wr_word.left  = in_l;
  assign wr_word.right = in_r;

  audio_fifo_ram #(
    .DEPTH (DEPTH),
    .DW    (2*WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en & ~reset),
    .waddr (wr_ptr),
    .wdata (wr_word),
    .raddr (rd_ptr),
    .rdata (head)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      stage_full <= 1'b0;
      l_data     <= '0;
      r_data     <= '0;
      underrun   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;

      if (refill) begin
        rd_ptr     <= rd_ptr + 1'b1;
        stage_full <= 1'b1;
        l_data     <= head.left;
        r_data     <= head.right;
      end else if (drain) begin
        stage_full <= 1'b0;
        l_data     <= '0;
        r_data     <= '0;
      end

      case ({wr_en, refill})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase

      if (underrun_set)      underrun <= 1'b1;
      else if (clr_underrun) underrun <= 1'b0;
    end
  end

`ifdef AUDIO_FIFO_UNDERRUN_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      underrun_cnt <= '0;
    end else if (underrun_set) begin
      // A clear on the same edge restarts the count at this event.
      if (clr_underrun)                underrun_cnt <= 16'd1;
      else if (underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
    end else if (clr_underrun) begin
      underrun_cnt <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Directed bench for audio_sample_fifo (DEPTH=16, WIDTH=24).
module tb_audio_sample_fifo;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic signed [23:0] in_l;
  logic signed [23:0] in_r;
  logic               load;
  logic signed [23:0] l_data;
  logic signed [23:0] r_data;
  logic [4:0]         level;
  logic               underrun;
  logic               clr_underrun;
`ifdef AUDIO_FIFO_UNDERRUN_CNT_EN
  logic [15:0]        underrun_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  audio_sample_fifo #(.DEPTH(16), .WIDTH(24)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_l         (in_l),
    .in_r         (in_r),
    .load         (load),
    .l_data       (l_data),
    .r_data       (r_data),
    .level        (level),
    .underrun     (underrun),
    .clr_underrun (clr_underrun)
`ifdef AUDIO_FIFO_UNDERRUN_CNT_EN
    ,
    .underrun_cnt (underrun_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] sl(input int i);
    return 24'(32'h100 + i);
  endfunction

  function automatic logic [23:0] sr(input int i);
    return 24'(32'hFFFFFF - i);
  endfunction

  initial begin
    int acc;
    int wi;
    int ri;
    int maxlvl;
    logic accept;

    reset = 1'b1; in_valid = 1'b0; in_l = '0; in_r = '0; load = 1'b0; clr_underrun = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_level", 48'(level), 48'd0);
    chk("rst_in_ready", 48'(in_ready), 48'd1);
    chk("rst_data", {l_data, r_data}, 48'd0);
    chk("rst_underrun", 48'(underrun), 48'd0);

    // Single sample: two-edge latency, then one load drains the stage.
    in_valid = 1'b1; in_l = 24'h000001; in_r = 24'h800000;
    tick();
    in_valid = 1'b0;
    chk("lat_edge1_data", {l_data, r_data}, 48'd0);
    chk("lat_edge1_level", 48'(level), 48'd1);
    tick();
    chk("lat_edge2_data", {l_data, r_data}, {24'h000001, 24'h800000});
    chk("lat_edge2_level", 48'(level), 48'd0);
    load = 1'b1;
    tick();
    load = 1'b0;
    chk("drain_data", {l_data, r_data}, 48'd0);
    chk("drain_underrun", 48'(underrun), 48'd0);

    // Underrun: set, sticky, clear, and set-beats-clear.
    load = 1'b1;
    tick();
    load = 1'b0;
    chk("ur_set", 48'(underrun), 48'd1);
    tick();
    chk("ur_sticky", 48'(underrun), 48'd1);
    clr_underrun = 1'b1;
    tick();
    clr_underrun = 1'b0;
    chk("ur_clear", 48'(underrun), 48'd0);
    load = 1'b1; clr_underrun = 1'b1;
    tick();
    load = 1'b0; clr_underrun = 1'b0;
    chk("ur_set_priority", 48'(underrun), 48'd1);
    clr_underrun = 1'b1;
    tick();
    clr_underrun = 1'b0;
    chk("ur_clear2", 48'(underrun), 48'd0);

    // Fill: stage takes sample 0, memory then holds 16 more.
    acc = 0;
    in_valid = 1'b1; in_l = sl(0); in_r = sr(0);
    for (int c = 0; c < 40 && in_ready; c++) begin
      tick();
      acc++;
      in_l = sl(acc); in_r = sr(acc);
    end
    chk("fill_accepted", 48'(acc), 48'd17);
    chk("fill_level", 48'(level), 48'd16);
    chk("fill_in_ready", 48'(in_ready), 48'd0);
    chk("fill_stage", {l_data, r_data}, {sl(0), sr(0)});
    tick();
    chk("full_hold_level", 48'(level), 48'd16);
    in_valid = 1'b0;
    for (int k = 0; k < 17; k++) begin
      chk($sformatf("order_%0d", k), {l_data, r_data}, {sl(k), sr(k)});
      load = 1'b1;
      tick();
      load = 1'b0;
    end
    chk("empty_data", {l_data, r_data}, 48'd0);
    chk("empty_level", 48'(level), 48'd0);
    chk("empty_underrun", 48'(underrun), 48'd0);

    // Streaming: producer always offers, load every 8 cycles.
    wi = 0; ri = 0; maxlvl = 0;
    in_valid = 1'b1; in_l = sl(1000); in_r = sr(1000);
    for (int c = 0; c < 3000 && ri < 200; c++) begin
      load = ((c % 8) == 7);
      if (load) begin
        chk("stream", {l_data, r_data}, {sl(1000 + ri), sr(1000 + ri)});
        ri++;
      end
      accept = in_valid && in_ready;
      tick();
      if (accept) wi++;
      in_valid = (wi < 200);
      in_l = sl(1000 + wi); in_r = sr(1000 + wi);
      if (int'(level) > maxlvl) maxlvl = int'(level);
    end
    load = 1'b0; in_valid = 1'b0;
    chk("stream_count", 48'(ri), 48'd200);
    chk("stream_written", 48'(wi), 48'd200);
    chk("stream_underrun", 48'(underrun), 48'd0);
    chk("stream_level_bound", 48'(maxlvl <= 16), 48'd1);

    // Mid-stream reset with level 5; the write and load of that cycle are dropped.
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_l = sl(500 + i); in_r = sr(500 + i);
      tick();
    end
    in_valid = 1'b0;
    chk("pre_rst_level", 48'(level), 48'd5);
    chk("pre_rst_stage", {l_data, r_data}, {sl(500), sr(500)});
    reset = 1'b1; in_valid = 1'b1; load = 1'b1;
    tick();
    reset = 1'b0; in_valid = 1'b0; load = 1'b0;
    chk("mid_rst_level", 48'(level), 48'd0);
    chk("mid_rst_data", {l_data, r_data}, 48'd0);
    chk("mid_rst_in_ready", 48'(in_ready), 48'd1);
    chk("mid_rst_underrun", 48'(underrun), 48'd0);
    tick();
    chk("post_rst_data", {l_data, r_data}, 48'd0);
    load = 1'b1;
    tick();
    load = 1'b0;
    chk("post_rst_underrun", 48'(underrun), 48'd1);

`ifdef AUDIO_FIFO_UNDERRUN_CNT_EN
    clr_underrun = 1'b1;
    tick();
    clr_underrun = 1'b0;
    chk("cnt_clear0", 48'(underrun_cnt), 48'd0);
    load = 1'b1;
    repeat (3) tick();
    chk("cnt_three", 48'(underrun_cnt), 48'd3);
    repeat (69997) tick();
    chk("cnt_saturate", 48'(underrun_cnt), 48'hFFFF);
    clr_underrun = 1'b1;
    tick();
    chk("cnt_clr_priority", 48'(underrun_cnt), 48'd1);
    load = 1'b0;
    tick();
    clr_underrun = 1'b0;
    chk("cnt_clear", 48'(underrun_cnt), 48'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
